// File: rtl/imem_program_loader.sv
// imem_program_loader
// Debug-unit loader: takes the uart_rx byte stream and writes it into the
// IF-stage instruction memory, big-endian, starting at address 0. Loading
// stops once a 4-byte aligned word equal to HALT_WORD has been written (the
// halt word is stored), or with an error when a byte arrives after the memory
// is already full. o_done is what lets the debug unit move on to RUN.
module imem_program_loader #(
  parameter int          MEM_BYTES = 256,
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [7:0]        o_imem_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_overflow,
  output logic [ADDR_W-2:0] o_word_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_ERROR = 2'd3;

  // One extra bit so that "memory full" is a distinct count, not address 0.
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(MEM_BYTES);

  logic [1:0]      state;
  logic [1:0]      state_next;
  logic [ADDR_W:0] byte_cnt;
  logic [23:0]     shift;      // the three previous bytes of the current word
  logic [31:0]     word_next;
  logic            load_entry;
  logic            accept;
  logic            overflow_hit;
  logic            word_end;
  logic            halt_hit;

  // Decode what the current byte does and where the FSM goes next.
  always_comb begin
    // NOTE: every signal gets a default first, so no path can leave one
    // unassigned and infer a latch.
    state_next   = state;
    load_entry   = (state != S_LOAD) && i_start;
    accept       = (state == S_LOAD) && i_rx_valid && (byte_cnt != FULL_CNT);
    overflow_hit = (state == S_LOAD) && i_rx_valid && (byte_cnt == FULL_CNT);
    word_next    = {shift, i_rx_data};
    word_end     = accept && (byte_cnt[1:0] == 2'd3);
    halt_hit     = word_end && (word_next == HALT_WORD);

    case (state)
      S_LOAD: begin
        // i_start is deliberately ignored here; a running load is never restarted.
        if (halt_hit) begin
          state_next = S_DONE;
        end else if (overflow_hit) begin
          state_next = S_ERROR;
        end
      end
      default: begin
        // IDLE, DONE and ERROR all restart on i_start; a byte in the same
        // cycle is dropped because accept requires LOAD.
        if (i_start) begin
          state_next = S_LOAD;
        end
      end
    endcase
  end

  // State, status flags, counters and the registered write port.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state        <= S_IDLE;
      byte_cnt     <= '0;
      shift        <= '0;
      o_imem_we    <= 1'b0;
      o_imem_addr  <= '0;
      o_imem_data  <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_overflow   <= 1'b0;
      o_word_count <= '0;
    end else begin
      state      <= state_next;
      o_busy     <= (state_next == S_LOAD);
      o_done     <= (state_next == S_DONE);
      o_overflow <= (state_next == S_ERROR);
      o_imem_we  <= accept;

      if (load_entry) begin
        byte_cnt     <= '0;
        shift        <= '0;
        o_word_count <= '0;
      end else if (accept) begin
        // Address and data only move on a write; otherwise they hold.
        o_imem_addr <= byte_cnt[ADDR_W-1:0];
        o_imem_data <= i_rx_data;
        byte_cnt    <= byte_cnt + 1'b1;
        shift       <= word_next[23:0];
        if (word_end) begin
          o_word_count <= o_word_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_program_loader.sv
// Bench for imem_program_loader. Two instances share one stimulus stream:
// a 256-byte memory and an 8-byte memory (so overflow is reachable). A
// byte-array model predicts every output each cycle; directed phases add
// hand-computed literal expectations, then a randomized phase runs.
module tb_imem_program_loader;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       valid;
  logic [7:0] rx;

  logic       we0, busy0, done0, ovf0;
  logic [7:0] addr0, data0;
  logic [6:0] wc0;

  logic       we1, busy1, done1, ovf1;
  logic [2:0] addr1;
  logic [7:0] data1;
  logic [1:0] wc1;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  imem_program_loader #(.MEM_BYTES(256), .ADDR_W(8), .HALT_WORD(HALT)) dut_big (
    .clk(clk), .rst(rst), .i_start(start), .i_rx_data(rx), .i_rx_valid(valid),
    .o_imem_we(we0), .o_imem_addr(addr0), .o_imem_data(data0),
    .o_busy(busy0), .o_done(done0), .o_overflow(ovf0), .o_word_count(wc0)
  );

  imem_program_loader #(.MEM_BYTES(8), .ADDR_W(3), .HALT_WORD(HALT)) dut_small (
    .clk(clk), .rst(rst), .i_start(start), .i_rx_data(rx), .i_rx_valid(valid),
    .o_imem_we(we1), .o_imem_addr(addr1), .o_imem_data(data1),
    .o_busy(busy1), .o_done(done1), .o_overflow(ovf1), .o_word_count(wc1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 loading, 2 finished, 3 overflowed
  int   mb[2] = '{256, 8};
  int   m_mode[2];
  int   m_cnt[2];
  int   m_wc[2];
  bit   m_we[2];
  int   m_addr[2];
  int   m_data[2];
  logic [7:0] m_img[2][256];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      m_we[k] = 1'b0;
      if (rst) begin
        m_mode[k] = 0; m_cnt[k] = 0; m_wc[k] = 0; m_addr[k] = 0; m_data[k] = 0;
      end else if (m_mode[k] != 1 && start) begin
        m_mode[k] = 1; m_cnt[k] = 0; m_wc[k] = 0;
      end else if (m_mode[k] == 1 && valid) begin
        if (m_cnt[k] == mb[k]) begin
          m_mode[k] = 3;
        end else begin
          m_img[k][m_cnt[k]] = rx;
          m_we[k]   = 1'b1;
          m_addr[k] = m_cnt[k];
          m_data[k] = int'(rx);
          if (m_cnt[k] % 4 == 3) begin
            m_wc[k] = (m_cnt[k] + 1) / 4;
            if ({m_img[k][m_cnt[k]-3], m_img[k][m_cnt[k]-2],
                 m_img[k][m_cnt[k]-1], m_img[k][m_cnt[k]]} == HALT)
              m_mode[k] = 2;
          end
          m_cnt[k]++;
        end
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("big_we",    32'(we0),   32'(m_we[0]));
      check("big_addr",  32'(addr0), 32'(m_addr[0]));
      check("big_data",  32'(data0), 32'(m_data[0]));
      check("big_busy",  32'(busy0), 32'(m_mode[0] == 1));
      check("big_done",  32'(done0), 32'(m_mode[0] == 2));
      check("big_ovf",   32'(ovf0),  32'(m_mode[0] == 3));
      check("big_wc",    32'(wc0),   32'(m_wc[0]));
      check("small_we",   32'(we1),   32'(m_we[1]));
      check("small_addr", 32'(addr1), 32'(m_addr[1]));
      check("small_data", 32'(data1), 32'(m_data[1]));
      check("small_busy", 32'(busy1), 32'(m_mode[1] == 1));
      check("small_done", 32'(done1), 32'(m_mode[1] == 2));
      check("small_ovf",  32'(ovf1),  32'(m_mode[1] == 3));
      check("small_wc",   32'(wc1),   32'(m_wc[1]));
    end
  end

  // Capture of what the big instance actually wrote.
  logic [7:0] cap[256];
  always @(negedge clk) if (we0 === 1'b1) cap[addr0] = data0;

  // One clock of stimulus; returns 1 time unit after the edge that used it.
  task automatic cyc(input logic s, input logic v, input logic [7:0] d);
    start = s; valid = v; rx = d;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0, 1'b0, 8'h00);
    rst = 1'b0;
  endtask

  logic [7:0] prog[16] = '{8'h85, 8'h08, 8'h00, 8'h00, 8'h21, 8'h09, 8'h00, 8'h04,
                           8'h01, 8'h20, 8'h50, 8'h09, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
  logic [7:0] mis[8]   = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};

  initial begin
    rst = 1'b1; start = 1'b0; valid = 1'b0; rx = 8'h00;

    // 1: two reset cycles, all outputs zero, stray byte ignored
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_we",   32'(we0),   32'd0);
    check("rst_addr", 32'(addr0), 32'd0);
    check("rst_data", 32'(data0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_ovf",  32'(ovf0),  32'd0);
    check("rst_wc",   32'(wc0),   32'd0);
    chk_en = 1'b1;
    rst = 1'b0;
    cyc(1'b0, 1'b1, 8'h55);
    check("idle_byte_no_we", 32'(we0), 32'd0);
    cyc(1'b0, 1'b0, 8'h00);

    // 2: full program terminated by the halt word
    for (int i = 0; i < 256; i++) cap[i] = 8'h00;
    cyc(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, prog[i]);
    check("prog_last_we",   32'(we0),   32'd1);
    check("prog_last_addr", 32'(addr0), 32'd15);
    check("prog_done",      32'(done0), 32'd1);
    check("prog_busy",      32'(busy0), 32'd0);
    check("prog_wc",        32'(wc0),   32'd4);
    cyc(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++) check($sformatf("prog_mem_%0d", i), 32'(cap[i]), 32'(prog[i]));

    // 3: FF run straddling a word boundary does not terminate
    do_reset();
    cyc(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, mis[i]);
    check("mis_done", 32'(done0), 32'd0);
    check("mis_busy", 32'(busy0), 32'd1);
    check("mis_wc",   32'(wc0),   32'd2);

    // 4: 8-byte memory overflow, then an exact-fit halt
    do_reset();
    cyc(1'b1, 1'b0, 8'h00);
    for (int i = 1; i <= 8; i++) cyc(1'b0, 1'b1, 8'(i));
    check("fill_last_addr", 32'(addr1), 32'd7);
    check("fill_no_ovf",    32'(ovf1),  32'd0);
    cyc(1'b0, 1'b1, 8'h09);
    check("ovf_flag", 32'(ovf1),  32'd1);
    check("ovf_no_we", 32'(we1),  32'd0);
    check("ovf_busy", 32'(busy1), 32'd0);
    do_reset();
    cyc(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 8'hFF);
    check("fit_done",   32'(done1), 32'd1);
    check("fit_no_ovf", 32'(ovf1),  32'd0);
    check("fit_addr",   32'(addr1), 32'd7);

    // 5: reset in the middle of a load, then a clean reload
    do_reset();
    cyc(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, prog[i]);
    rst = 1'b1;
    cyc(1'b0, 1'b1, 8'h77);
    rst = 1'b0;
    check("midrst_busy", 32'(busy0), 32'd0);
    check("midrst_we",   32'(we0),   32'd0);
    check("midrst_addr", 32'(addr0), 32'd0);
    check("midrst_wc",   32'(wc0),   32'd0);
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, prog[0]);
    check("reload_first_addr", 32'(addr0), 32'd0);
    for (int i = 1; i < 16; i++) cyc(1'b0, 1'b1, prog[i]);
    check("reload_done", 32'(done0), 32'd1);

    // 6: restart from DONE, start pulses ignored during LOAD
    cyc(1'b1, 1'b0, 8'h00);
    check("restart_busy", 32'(busy0), 32'd1);
    check("restart_wc",   32'(wc0),   32'd0);
    cyc(1'b0, 1'b1, 8'hAA);
    check("restart_addr", 32'(addr0), 32'd0);
    check("restart_data", 32'(data0), 32'hAA);
    for (int i = 1; i <= 6; i++) cyc(1'(i % 2), 1'b1, 8'(i));
    check("ign_start_addr", 32'(addr0), 32'd6);
    check("ign_start_busy", 32'(busy0), 32'd1);

    // Randomized phase: bytes biased towards FF so halts occur often.
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      cyc(($urandom_range(0, 29) == 0), $urandom_range(0, 1) == 1,
          ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom));
    end
    rst = 1'b0;
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
